// File: rtl/timer_sched_if.sv
// Timer peripheral register bus as seen from the scheduler.
// master: scheduler side (drives strobes, address, write data).
// slave : timer side (returns read data and the interrupt line).
//   bus_write_en   write strobe, single cycle
//   bus_read_en    read strobe, single cycle
//   bus_addr       register address
//   bus_write_data write data
//   bus_read_data  read data, valid the cycle after bus_read_en
//   fabint         timer interrupt, may be a one-cycle pulse
interface timer_sched_if;
   logic        bus_write_en;
   logic        bus_read_en;
   logic [31:0] bus_addr;
   logic [31:0] bus_write_data;
   logic [31:0] bus_read_data;
   logic        fabint;

   modport master (
      output bus_write_en, bus_read_en, bus_addr, bus_write_data,
      input  bus_read_data, fabint
   );

   modport slave (
      input  bus_write_en, bus_read_en, bus_addr, bus_write_data,
      output bus_read_data, fabint
   );
endinterface

// File: rtl/timer_sched.sv
// Shares one fabric timer between N one-shot delay requesters.
// A round-robin arbiter grants a pending req, programs the timer (overflow,
// then control), waits for fabint, reads/clears the status, stops the timer
// and pulses done for the winner.
//   pclk, reset  clock, asynchronous active-high reset
//   req          per-requester request level, held until ack
//   delay        requester i delay at [i*DELAY_W +: DELAY_W], sampled at grant
//   ack, done    one-cycle per-requester pulses
//   err          pulses with done when captured status bit0 was 0
//   busy         high in every state except IDLE
//   bus          timer register bus (master side)
module timer_sched #(
   parameter int unsigned N          = 4,
   parameter int unsigned DELAY_W    = 32,
   parameter logic [31:0] TIMER_BASE = 32'h0000_0000
) (
   input  logic                 pclk,
   input  logic                 reset,
   input  logic [N-1:0]         req,
   input  logic [N*DELAY_W-1:0] delay,
   output logic [N-1:0]         ack,
   output logic [N-1:0]         done,
   output logic                 err,
   output logic                 busy,
   timer_sched_if.master        bus
);

   localparam int unsigned IDX_W    = (N > 1) ? $clog2(N) : 1;
   localparam logic [31:0] ADDR_OVF  = TIMER_BASE + 32'h0000_0000;
   localparam logic [31:0] ADDR_CTRL = TIMER_BASE + 32'h0000_0008;
   localparam logic [31:0] ADDR_STAT = TIMER_BASE + 32'h0000_0010;
   // enable | interrupt enable | overflow interrupt enable
   localparam logic [31:0] CTRL_RUN  = 32'h0000_000B;

   typedef enum logic [3:0] {
      INIT, IDLE, WR_OVF, WR_CTRL, WAIT, RD_STAT, CAPT, STOP, DONE
   } stateE;

   stateE               stateQ, stateNext;
   logic [DELAY_W-1:0]  dlyQ, dlyNext;
   logic [IDX_W-1:0]    gQ, gNext;
   logic [1:0]          stQ, stNext;
   logic [IDX_W-1:0]    ptrQ, ptrNext;
   logic [N-1:0]        ackNext, doneNext;
   logic                errNext, busyNext;
   logic                wrNext, rdNext;
   logic [31:0]         addrNext, dataNext;
   logic [IDX_W-1:0]    grantIdx;
   logic [DELAY_W-1:0]  grantDly;

   // First set req bit at or above p, wrapping; scanned downward so the
   // closest candidate is the last one assigned.
   function automatic logic [IDX_W-1:0] pickNext(input logic [N-1:0] r,
                                                 input logic [IDX_W-1:0] p);
      logic [IDX_W-1:0] g;
      int idx;
      g = p;
      for (int k = int'(N) - 1; k >= 0; k--) begin
         idx = (int'(p) + k) % int'(N);
         if (r[IDX_W'(idx)]) g = IDX_W'(idx);
      end
      return g;
   endfunction

   assign grantIdx = pickNext(req, ptrQ);
   assign grantDly = delay[32'(grantIdx) * DELAY_W +: DELAY_W];

   // State and registered outputs
   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         stateQ             <= INIT;
         dlyQ               <= '0;
         gQ                 <= '0;
         stQ                <= '0;
         ptrQ               <= '0;
         ack                <= '0;
         done               <= '0;
         err                <= 1'b0;
         busy               <= 1'b1;
         bus.bus_write_en   <= 1'b0;
         bus.bus_read_en    <= 1'b0;
         bus.bus_addr       <= '0;
         bus.bus_write_data <= '0;
      end else begin
         stateQ             <= stateNext;
         dlyQ               <= dlyNext;
         gQ                 <= gNext;
         stQ                <= stNext;
         ptrQ               <= ptrNext;
         ack                <= ackNext;
         done               <= doneNext;
         err                <= errNext;
         busy               <= busyNext;
         bus.bus_write_en   <= wrNext;
         bus.bus_read_en    <= rdNext;
         bus.bus_addr       <= addrNext;
         bus.bus_write_data <= dataNext;
      end
   end

   // Next state; registered outputs are computed for the state being entered
   // so each strobe lines up with its state (read data then lands in CAPT).
   // INIT is the exception: its stop write appears in the first IDLE cycle.
   always_comb begin
      stateNext = stateQ;
      dlyNext   = dlyQ;
      gNext     = gQ;
      stNext    = stQ;
      ptrNext   = ptrQ;
      ackNext   = '0;
      doneNext  = '0;
      errNext   = 1'b0;
      wrNext    = 1'b0;
      rdNext    = 1'b0;
      addrNext  = bus.bus_addr;
      dataNext  = bus.bus_write_data;

      case (stateQ)
         INIT: begin
            stateNext = IDLE;
            wrNext    = 1'b1;
            addrNext  = ADDR_CTRL;
            dataNext  = '0;
         end
         IDLE: begin
            if (|req) begin
               stateNext         = WR_OVF;
               dlyNext           = grantDly;
               gNext             = grantIdx;
               ackNext[grantIdx] = 1'b1;
               wrNext            = 1'b1;
               addrNext          = ADDR_OVF;
               dataNext          = 32'(grantDly);
            end
         end
         WR_OVF: begin
            stateNext = WR_CTRL;
            wrNext    = 1'b1;
            addrNext  = ADDR_CTRL;
            dataNext  = CTRL_RUN;
         end
         WR_CTRL: stateNext = WAIT;
         WAIT: begin
            if (bus.fabint) begin
               stateNext = RD_STAT;
               rdNext    = 1'b1;
               addrNext  = ADDR_STAT;
            end
         end
         RD_STAT: stateNext = CAPT;
         CAPT: begin
            stNext    = bus.bus_read_data[1:0];
            stateNext = STOP;
            wrNext    = 1'b1;
            addrNext  = ADDR_CTRL;
            dataNext  = '0;
         end
         STOP: begin
            stateNext    = DONE;
            doneNext[gQ] = 1'b1;
            errNext      = ~stQ[0];
         end
         DONE: begin
            stateNext = IDLE;
            ptrNext   = (gQ == IDX_W'(N - 1)) ? '0 : gQ + IDX_W'(1);
         end
         default: stateNext = INIT;
      endcase

      busyNext = (stateNext != IDLE);
   end

endmodule
